// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: shared widths, descriptor types and byte-mask helper for the
// traffic generator / checker pair.
package rtl_settings_pkg;
   localparam int AMM_DATA_W  = 32;
   localparam int DATA_B_W    = AMM_DATA_W / 8;
   localparam int ADDR_B_W    = $clog2(DATA_B_W);
   localparam int AMM_BURST_W = 4;
   localparam int AMM_ADDR_W  = 16;
   localparam     ADDR_TYPE   = "BYTE";

   typedef enum logic {FIX_DATA = 1'b0, RND_DATA = 1'b1} data_mode_t;
   typedef enum logic [1:0] {IDLE, CHECK, DRAIN} cmp_state_t;

   typedef struct packed {
      logic [AMM_ADDR_W-1:0]  start_addr;
      logic [ADDR_B_W-1:0]    start_off;
      logic [ADDR_B_W-1:0]    end_off;
      logic [AMM_BURST_W-2:0] words_count;
      data_mode_t             data_mode;
      logic [7:0]             data_ptrn;
   } cmp_struct_t;

   // first beat keeps bytes from start_off up, last beat keeps bytes up to end_off
   function automatic logic [DATA_B_W-1:0] cmp_byte_mask(input logic first, input logic last,
                                                         input logic [ADDR_B_W-1:0] start_off,
                                                         input logic [ADDR_B_W-1:0] end_off);
      logic [DATA_B_W-1:0] m;
      for (int i = 0; i < DATA_B_W; i++)
         m[i] = (!first || ADDR_B_W'(i) >= start_off) && (!last || ADDR_B_W'(i) <= end_off);
      return m;
   endfunction
endpackage

// File: rtl/compare_block_if.sv
// compare_block_if: Avalon-MM read-response beats seen by the checker.
interface compare_block_if;
   import rtl_settings_pkg::*;
   logic                  readdatavalid;
   logic [AMM_DATA_W-1:0] readdata;
   modport master (output readdatavalid, readdata);
   modport slave  (input  readdatavalid, readdata);
endinterface

// File: rtl/rnd_gen_8.sv
// rnd_gen_8: one step of the 8-bit pattern LFSR shared with the transmitter.
module rnd_gen_8 (
   input  logic [7:0] d_i,
   output logic [7:0] q_o
);
   assign q_o = {d_i[6:0], d_i[6] ^ d_i[1] ^ d_i[0]};
endmodule

// File: rtl/compare_block.sv
// compare_block: checks read-back beats against the expected pattern and
// captures the first failing word.
module compare_block
   import rtl_settings_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  cmp_en_i,
   input  cmp_struct_t           cmp_struct_i,
   compare_block_if.slave        amm,
   output logic                  cmp_busy_o,
   output logic                  cmp_error_o,
   output logic                  err_valid_o,
   output logic [AMM_ADDR_W-1:0] err_addr_o,
   output logic [AMM_DATA_W-1:0] err_data_o
);
   cmp_state_t             state, state_nxt;
   logic [AMM_ADDR_W-1:0]  base_addr;
   logic [ADDR_B_W-1:0]    s_off, e_off;
   data_mode_t             mode;
   logic [AMM_BURST_W-2:0] beat_cnt, beat_idx;
   logic [7:0]             exp_byte, exp_nxt;
   logic [DATA_B_W-1:0]    mask;
   logic                   first, last, mism, start, hit;

   assign first = beat_idx == '0;
   assign last  = beat_cnt == '0;

   rnd_gen_8 u_rnd (.d_i(exp_byte), .q_o(exp_nxt));

   generate
      if (ADDR_TYPE == "BYTE") begin : g_byte
         assign mask = cmp_byte_mask(first, last, s_off, e_off);
      end else begin : g_word
         assign mask = '1;
      end
   endgenerate

   always_comb begin
      mism = 1'b0;
      for (int b = 0; b < DATA_B_W; b++)
         mism = mism | (mask[b] && amm.readdata[8*b +: 8] != exp_byte);
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nxt;

   always_comb begin
      state_nxt = state == IDLE                                  ? (cmp_en_i ? CHECK : IDLE) :
                  amm.readdatavalid && last                      ? IDLE :
                  state == CHECK && amm.readdatavalid && mism    ? DRAIN : state;
   end

   always_comb begin
      cmp_busy_o = state != IDLE;
      start      = state == IDLE && cmp_en_i;
      hit        = state == CHECK && amm.readdatavalid && mism;
   end

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         base_addr   <= '0;
         s_off       <= '0;
         e_off       <= '0;
         mode        <= FIX_DATA;
         beat_cnt    <= '0;
         beat_idx    <= '0;
         exp_byte    <= 8'hFF;
         cmp_error_o <= 1'b0;
         err_valid_o <= 1'b0;
         err_addr_o  <= '0;
         err_data_o  <= '0;
      end else begin
         cmp_error_o <= hit;
         if (start) begin
            base_addr   <= cmp_struct_i.start_addr;
            s_off       <= cmp_struct_i.start_off;
            e_off       <= cmp_struct_i.end_off;
            mode        <= cmp_struct_i.data_mode;
            beat_cnt    <= cmp_struct_i.words_count;
            beat_idx    <= '0;
            exp_byte    <= cmp_struct_i.data_ptrn;
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_data_o  <= '0;
         end else if (cmp_busy_o && amm.readdatavalid) begin
            beat_cnt <= beat_cnt - 1'b1;
            beat_idx <= beat_idx + 1'b1;
            if (mode == RND_DATA) exp_byte <= exp_nxt;
         end
         // only CHECK can hit, so DRAIN never overwrites the first error
         if (hit) begin
            err_valid_o <= 1'b1;
            err_addr_o  <= base_addr + AMM_ADDR_W'(beat_idx);
            err_data_o  <= amm.readdata;
         end
      end
endmodule

// File: tb/tb_compare_block.sv
// tb_compare_block: directed checks of compare_block with hand-computed expectations.
module tb_compare_block;
   import rtl_settings_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  cmp_en;
   cmp_struct_t           cs;
   logic                  busy, err, ev;
   logic [AMM_ADDR_W-1:0] eaddr;
   logic [AMM_DATA_W-1:0] edata;
   int                    n_chk = 0;
   int                    n_fail = 0;

   compare_block_if amm();

   compare_block dut (
      .clk_i(clk), .rst_n_i(rst_n), .cmp_en_i(cmp_en), .cmp_struct_i(cs), .amm(amm),
      .cmp_busy_o(busy), .cmp_error_o(err), .err_valid_o(ev), .err_addr_o(eaddr), .err_data_o(edata)
   );

   always #5 clk = ~clk;

   function automatic cmp_struct_t mk(input logic [15:0] a, input logic [1:0] so, input logic [1:0] eo,
                                      input logic [2:0] wc, input data_mode_t m, input logic [7:0] p);
      cmp_struct_t d;
      d.start_addr = a;
      d.start_off = so;
      d.end_off = eo;
      d.words_count = wc;
      d.data_mode = m;
      d.data_ptrn = p;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input cmp_struct_t d);
      cs = d;
      cmp_en = 1'b1;
      tick();
      cmp_en = 1'b0;
   endtask

   task automatic beat(input logic [31:0] w);
      amm.readdatavalid = 1'b1;
      amm.readdata = w;
      tick();
      amm.readdatavalid = 1'b0;
      amm.readdata = '0;
   endtask

   task automatic test_reset();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", err); end
      n_chk++; if (ev !== 1'b0) begin n_fail++; $display("FAIL reset_err_valid: got %b expected 0", ev); end
      n_chk++; if (eaddr !== 16'h0) begin n_fail++; $display("FAIL reset_err_addr: got %h expected 0000", eaddr); end
      n_chk++; if (edata !== 32'h0) begin n_fail++; $display("FAIL reset_err_data: got %h expected 0", edata); end
   endtask

   task automatic test_word_pass();
      start(mk(16'h0100, 2'd0, 2'd3, 3'd3, FIX_DATA, 8'hA5));
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy_start: got %b expected 1", busy); end
      for (int i = 0; i < 4; i++) begin
         beat(32'hA5A5A5A5);
         n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL pass_error beat%0d: got %b expected 0", i, err); end
         n_chk++; if (busy !== (i < 3)) begin n_fail++; $display("FAIL pass_busy beat%0d: got %b expected %b", i, busy, i < 3); end
      end
      n_chk++; if (ev !== 1'b0) begin n_fail++; $display("FAIL pass_err_valid: got %b expected 0", ev); end
   endtask

   task automatic test_word_err();
      start(mk(16'h0100, 2'd0, 2'd3, 3'd3, FIX_DATA, 8'hA5));
      beat(32'hA5A5A5A5);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL werr_b1_error: got %b expected 0", err); end
      beat(32'hA5A5A500);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL werr_pulse: got %b expected 1", err); end
      n_chk++; if (ev !== 1'b1) begin n_fail++; $display("FAIL werr_valid: got %b expected 1", ev); end
      n_chk++; if (eaddr !== 16'h0101) begin n_fail++; $display("FAIL werr_addr: got %h expected 0101", eaddr); end
      n_chk++; if (edata !== 32'hA5A5A500) begin n_fail++; $display("FAIL werr_data: got %h expected a5a5a500", edata); end
      beat(32'h00000000);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL werr_pulse_fall: got %b expected 0", err); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL werr_drain_busy: got %b expected 1", busy); end
      beat(32'h11111111);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL werr_no_second: got %b expected 0", err); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL werr_busy_end: got %b expected 0", busy); end
      n_chk++; if (eaddr !== 16'h0101) begin n_fail++; $display("FAIL werr_addr_kept: got %h expected 0101", eaddr); end
      n_chk++; if (edata !== 32'hA5A5A500) begin n_fail++; $display("FAIL werr_data_kept: got %h expected a5a5a500", edata); end
   endtask

   task automatic test_byte_mask();
      start(mk(16'h0200, 2'd2, 2'd1, 3'd1, FIX_DATA, 8'h5A));
      n_chk++; if (ev !== 1'b0) begin n_fail++; $display("FAIL mask_err_cleared: got %b expected 0", ev); end
      n_chk++; if (eaddr !== 16'h0) begin n_fail++; $display("FAIL mask_addr_cleared: got %h expected 0000", eaddr); end
      beat(32'h5A5A1234);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL mask_first_garbage: got %b expected 0", err); end
      beat(32'hDEAD5A5A);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL mask_last_garbage: got %b expected 0", err); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mask_busy_end: got %b expected 0", busy); end
      start(mk(16'h0200, 2'd2, 2'd1, 3'd1, FIX_DATA, 8'h5A));
      beat(32'h5A001234);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL mask_byte2_error: got %b expected 1", err); end
      n_chk++; if (eaddr !== 16'h0200) begin n_fail++; $display("FAIL mask_byte2_addr: got %h expected 0200", eaddr); end
      n_chk++; if (edata !== 32'h5A001234) begin n_fail++; $display("FAIL mask_byte2_data: got %h expected 5a001234", edata); end
      beat(32'h5A5A5A5A);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mask_drain_end: got %b expected 0", busy); end
      // single beat: only bytes 1..2 are checked
      start(mk(16'h0210, 2'd1, 2'd2, 3'd0, FIX_DATA, 8'h5A));
      beat(32'hEE5A5AEE);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_pass: got %b expected 0", err); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
      start(mk(16'h0210, 2'd1, 2'd2, 3'd0, FIX_DATA, 8'h5A));
      beat(32'hEE5A00EE);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL single_error: got %b expected 1", err); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_err_idle: got %b expected 0", busy); end
      n_chk++; if (eaddr !== 16'h0210) begin n_fail++; $display("FAIL single_addr: got %h expected 0210", eaddr); end
   endtask

   task automatic test_rnd();
      // seed FF is a fixed point of the LFSR step
      start(mk(16'h0300, 2'd0, 2'd3, 3'd2, RND_DATA, 8'hFF));
      for (int i = 0; i < 3; i++) beat(32'hFFFFFFFF);
      n_chk++; if (ev !== 1'b0) begin n_fail++; $display("FAIL rnd_ff_pass: got %b expected 0", ev); end
      // seed 01 -> 03 -> 06
      start(mk(16'h0300, 2'd0, 2'd3, 3'd2, RND_DATA, 8'h01));
      beat(32'h01010101);
      beat(32'h03030303);
      beat(32'h06060606);
      n_chk++; if (ev !== 1'b0) begin n_fail++; $display("FAIL rnd_seq_pass: got %b expected 0", ev); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_seq_busy: got %b expected 0", busy); end
      start(mk(16'h0300, 2'd0, 2'd3, 3'd2, RND_DATA, 8'h01));
      beat(32'h01010101);
      beat(32'h06060606);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL rnd_swap_error: got %b expected 1", err); end
      n_chk++; if (eaddr !== 16'h0301) begin n_fail++; $display("FAIL rnd_swap_addr: got %h expected 0301", eaddr); end
      n_chk++; if (edata !== 32'h06060606) begin n_fail++; $display("FAIL rnd_swap_data: got %h expected 06060606", edata); end
      beat(32'h03030303);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rnd_swap_single: got %b expected 0", err); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_swap_busy: got %b expected 0", busy); end
   endtask

   task automatic test_addr_wrap();
      start(mk(16'hFFFF, 2'd0, 2'd3, 3'd2, FIX_DATA, 8'h3C));
      beat(32'h3C3C3C3C);
      beat(32'h3C3CFF3C);
      n_chk++; if (eaddr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h expected 0000", eaddr); end
      beat(32'h3C3C3C3C);
   endtask

   task automatic test_max_len();
      start(mk(16'h1000, 2'd0, 2'd3, 3'd7, FIX_DATA, 8'hC3));
      for (int i = 0; i < 7; i++) begin
         beat(32'hC3C3C3C3);
         n_chk++; if (busy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL maxlen_beat%0d: got busy %b err %b expected 1 0", i, busy, err); end
      end
      beat(32'hC3C3C3C2);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL maxlen_last_error: got %b expected 1", err); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL maxlen_busy: got %b expected 0", busy); end
      n_chk++; if (eaddr !== 16'h1007) begin n_fail++; $display("FAIL maxlen_addr: got %h expected 1007", eaddr); end
      tick();
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL maxlen_pulse_fall: got %b expected 0", err); end
   endtask

   task automatic test_en_ignored();
      start(mk(16'h0300, 2'd0, 2'd3, 3'd2, FIX_DATA, 8'h11));
      beat(32'h11111111);
      cs = mk(16'h0400, 2'd0, 2'd3, 3'd0, FIX_DATA, 8'h22);
      cmp_en = 1'b1;
      beat(32'h11111111);
      cmp_en = 1'b0;
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL en_ignored_error: got %b expected 0", err); end
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL en_ignored_busy: got %b expected 1", busy); end
      beat(32'h11111100);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL en_ignored_last_err: got %b expected 1", err); end
      n_chk++; if (eaddr !== 16'h0302) begin n_fail++; $display("FAIL en_ignored_addr: got %h expected 0302", eaddr); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_ignored_end: got %b expected 0", busy); end
   endtask

   task automatic test_rdv_idle();
      tick();
      beat(32'hDEADBEEF);
      beat(32'h00000000);
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_beat_busy: got %b expected 0", busy); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL idle_beat_error: got %b expected 0", err); end
   endtask

   task automatic test_reset_mid();
      start(mk(16'h0500, 2'd0, 2'd3, 3'd2, FIX_DATA, 8'h77));
      beat(32'h00777777);
      n_chk++; if (ev !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_err: got %b expected 1", ev); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_error: got %b expected 0", err); end
      n_chk++; if (ev !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", ev); end
      n_chk++; if (eaddr !== 16'h0) begin n_fail++; $display("FAIL rstmid_addr: got %h expected 0000", eaddr); end
      n_chk++; if (edata !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", edata); end
      tick();
      rst_n = 1'b1;
      tick();
      start(mk(16'h0500, 2'd0, 2'd3, 3'd1, FIX_DATA, 8'h77));
      beat(32'h77777777);
      n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_b1: got %b expected 0", err); end
      beat(32'h77770077);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL rstmid_post_err: got %b expected 1", err); end
      n_chk++; if (eaddr !== 16'h0501) begin n_fail++; $display("FAIL rstmid_post_addr: got %h expected 0501", eaddr); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_post_busy: got %b expected 0", busy); end
   endtask

   initial begin
      rst_n = 1'b0;
      cmp_en = 1'b0;
      cs = '0;
      amm.readdatavalid = 1'b0;
      amm.readdata = '0;
      #2;
      test_reset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      test_word_pass();
      test_word_err();
      test_byte_mask();
      test_rnd();
      test_addr_wrap();
      test_max_len();
      test_en_ignored();
      test_rdv_idle();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
